// File: rtl/vseq_lane.sv
// vseq_lane: element sequencer feeding the vector ALU and collecting writes/compare masks
module vseq_lane #(
  parameter int VLMAX = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       vl,
  input  logic [4:0]       op,
  input  logic             masked,
  output logic             busy,
  output logic             done,
  output logic [IDXW-1:0]  rd_idx,
  output logic             rd_en,
  input  logic [31:0]      rd_opd1,
  input  logic [31:0]      rd_opd2,
  input  logic             rd_v0,
  output logic [31:0]      alu_opd1,
  output logic [31:0]      alu_opd2,
  output logic [4:0]       alu_op,
  output logic             alu_vm,
  input  logic [31:0]      alu_result,
  output logic             wr_en,
  output logic [IDXW-1:0]  wr_idx,
  output logic [31:0]      wr_data,
  output logic [VLMAX-1:0] mask_out
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [4:0] OP_MERGE = 5'b10101;
  state_t state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d, stage_idx_q, stage_idx_d;
  logic [IDXW:0] eff_vl_q, eff_vl_d, vl_clamp;
  logic [4:0] op_q, op_d;
  logic masked_q, masked_d, stage_valid_q, stage_valid_d;
  logic [VLMAX-1:0] mask_acc_q, mask_acc_d;
  logic is_cmp, last;
  assign vl_clamp = (vl > 6'(VLMAX)) ? (IDXW+1)'(VLMAX) : vl[IDXW:0];
  assign is_cmp   = (op_q >= 5'd9) && (op_q <= 5'd16);
  assign last     = {1'b0, cnt_q} == eff_vl_q - (IDXW+1)'(1);
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign rd_en    = state_q == RUN;
  assign rd_idx   = cnt_q;
  assign alu_opd1 = rd_opd1;
  assign alu_opd2 = rd_opd2;
  assign alu_op   = op_q;
  assign alu_vm   = stage_valid_q & (~masked_q | rd_v0);
  assign wr_en    = stage_valid_q & ~is_cmp & ((op_q == OP_MERGE) | alu_vm);
  assign wr_idx   = stage_idx_q;
  assign wr_data  = alu_result;
  assign mask_out = mask_acc_q;
  // next-state: sequencing FSM, element stage pipeline and mask accumulation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    eff_vl_d      = eff_vl_q;
    op_d          = op_q;
    masked_d      = masked_q;
    mask_acc_d    = mask_acc_q;
    stage_valid_d = state_q == RUN;
    stage_idx_d   = cnt_q;
    if (stage_valid_q && is_cmp) mask_acc_d[stage_idx_q] = alu_result[0];
    case (state_q)
      IDLE: if (start) begin
        state_d    = (vl_clamp == '0) ? DONE : RUN;
        cnt_d      = '0;
        eff_vl_d   = vl_clamp;
        op_d       = op;
        masked_d   = masked;
        mask_acc_d = '0;
      end
      RUN: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? DRAIN : RUN;
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset abandoning any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      eff_vl_q      <= '0;
      op_q          <= '0;
      masked_q      <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_idx_q   <= '0;
      mask_acc_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      eff_vl_q      <= eff_vl_d;
      op_q          <= op_d;
      masked_q      <= masked_d;
      stage_valid_q <= stage_valid_d;
      stage_idx_q   <= stage_idx_d;
      mask_acc_q    <= mask_acc_d;
    end
  end
endmodule

// File: tb/tb_vseq_lane.sv
// tb_vseq_lane: randomized and directed checks of vseq_lane against a queue-based reference
module tb_vseq_lane;
  logic clk = 0, rst = 1, start = 0, masked = 0, rd_v0 = 0;
  logic [5:0] vl = 0;
  logic [4:0] op = 0;
  logic busy, done, rd_en, alu_vm, wr_en;
  logic [2:0] rd_idx, wr_idx;
  logic [31:0] rd_opd1 = 0, rd_opd2 = 0, alu_opd1, alu_opd2, alu_result, wr_data;
  logic [4:0] alu_op;
  logic [7:0] mask_out;
  logic [31:0] vs1 [8], vs2 [8];
  logic [7:0] v0;
  logic [31:0] last_mask = 0;
  int checks = 0, errors = 0;
  int exp_idx [$];
  logic [31:0] exp_data [$];

  vseq_lane #(.VLMAX(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .vl(vl), .op(op), .masked(masked),
    .busy(busy), .done(done), .rd_idx(rd_idx), .rd_en(rd_en),
    .rd_opd1(rd_opd1), .rd_opd2(rd_opd2), .rd_v0(rd_v0),
    .alu_opd1(alu_opd1), .alu_opd2(alu_opd2), .alu_op(alu_op), .alu_vm(alu_vm),
    .alu_result(alu_result), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .mask_out(mask_out)
  );

  always #5 clk = ~clk;

  // register file: synchronous read, data returns the cycle after rd_en
  always @(posedge clk) if (rd_en) begin
    rd_opd1 <= vs1[rd_idx];
    rd_opd2 <= vs2[rd_idx];
    rd_v0   <= v0[rd_idx];
  end

  // ALU: 0 add, 1 sub, 9 signed-lt, 10 eq, 21 merge (vm picks opd2)
  always_comb begin
    alu_result = 0;
    case (alu_op)
      5'd0:  alu_result = alu_opd1 + alu_opd2;
      5'd1:  alu_result = alu_opd1 - alu_opd2;
      5'd9:  alu_result = {31'b0, alu_vm && ($signed(alu_opd1) < $signed(alu_opd2))};
      5'd10: alu_result = {31'b0, alu_vm && (alu_opd1 == alu_opd2)};
      5'd21: alu_result = alu_vm ? alu_opd2 : alu_opd1;
      default: alu_result = 0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setv(input int i, input int a, input int b);
    vs1[i] = a;
    vs2[i] = b;
  endtask

  task automatic run_instr(input logic [4:0] o, input int n, input logic m);
    int eff, rds;
    logic act, got_done;
    logic [31:0] exp_mask;
    eff = n > 8 ? 8 : n;
    rds = 0;
    got_done = 0;
    exp_mask = 0;
    exp_idx.delete();
    exp_data.delete();
    for (int i = 0; i < eff; i++) begin
      act = !m || v0[i];
      if (o == 9 || o == 10)
        exp_mask[i] = act && (o == 9 ? ($signed(vs1[i]) < $signed(vs2[i])) : (vs1[i] == vs2[i]));
      else if (o == 21) begin
        exp_idx.push_back(i);
        exp_data.push_back(act ? vs2[i] : vs1[i]);
      end else if (act) begin
        exp_idx.push_back(i);
        exp_data.push_back(o == 0 ? vs1[i] + vs2[i] : vs1[i] - vs2[i]);
      end
    end
    @(negedge clk);
    chk("mask_hold", {24'b0, mask_out}, last_mask);
    chk("idle_busy", {31'b0, busy}, 0);
    start = 1; op = o; vl = 6'(n); masked = m;
    @(posedge clk);
    #1 start = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk("alu_op", {27'b0, alu_op}, {27'b0, o});
      if (rd_en) begin
        chk("rd_idx", {29'b0, rd_idx}, rds);
        rds++;
      end
      if (wr_en) begin
        if (exp_idx.size() == 0) chk("extra_wr", 1, 0);
        else begin
          chk("wr_idx", {29'b0, wr_idx}, exp_idx.pop_front());
          chk("wr_data", wr_data, exp_data.pop_front());
        end
      end
      if (done) begin
        chk("done_cyc", cyc, eff == 0 ? 1 : eff + 2);
        chk("busy_at_done", {31'b0, busy}, 1);
        chk("mask", {24'b0, mask_out}, exp_mask);
        got_done = 1;
        break;
      end
    end
    chk("got_done", {31'b0, got_done}, 1);
    chk("rd_count", rds, eff);
    chk("missing_wr", exp_idx.size(), 0);
    last_mask = exp_mask;
  endtask

  initial begin
    int bad;
    logic [4:0] ops [5];
    ops[0] = 0; ops[1] = 1; ops[2] = 9; ops[3] = 10; ops[4] = 21;
    for (int i = 0; i < 8; i++) setv(i, 0, 0);
    v0 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_rd_en", {31'b0, rd_en}, 0);
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_rd_idx", {29'b0, rd_idx}, 0);
    chk("rst_wr_idx", {29'b0, wr_idx}, 0);
    chk("rst_mask", {24'b0, mask_out}, 0);
    chk("rst_alu_op", {27'b0, alu_op}, 0);
    chk("rst_alu_vm", {31'b0, alu_vm}, 0);
    setv(0, 1, 10); setv(1, 2, 20); setv(2, 3, 30); setv(3, 4, 40);
    run_instr(5'd0, 4, 0);
    v0 = 8'b0000_1010;
    run_instr(5'd1, 4, 1);
    setv(0, -1, 0); setv(1, 5, 5); setv(2, 0, 1); setv(3, 7, -7);
    setv(4, -8, -9); setv(5, 2, 3); setv(6, 2, 2); setv(7, 3, 4);
    run_instr(5'd9, 8, 0);
    chk("vmslt_mask", {24'b0, mask_out}, 32'hA5);
    setv(0, 100, 7); setv(1, 200, 9);
    v0 = 8'b0000_0001;
    run_instr(5'd21, 2, 1);
    run_instr(5'd0, 0, 0);
    for (int i = 0; i < 8; i++) setv(i, $urandom, $urandom);
    run_instr(5'd0, 40, 0);
    // start held during the done cycle must be ignored
    start = 1; op = 0; vl = 6'd3; masked = 0;
    @(negedge clk);
    start = 0;
    chk("start_in_done_ignored", {31'b0, busy}, 0);
    // reset in the middle of a vl=8 run
    @(negedge clk);
    start = 1; op = 0; vl = 6'd8; masked = 0;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_rd_en", {31'b0, rd_en}, 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done || rd_en || wr_en) bad++;
    end
    chk("rst_quiet", bad, 0);
    chk("rst_mid_mask", {24'b0, mask_out}, 0);
    last_mask = 0;
    run_instr(5'd1, 5, 0);
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 8; i++) setv(i, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      v0 = 8'($urandom);
      run_instr(ops[$urandom_range(0, 4)], ($urandom_range(0, 5) == 0) ? int'($urandom_range(9, 63)) : int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vseq_lane.md
# vseq_lane

Element sequencer that drives the vector ALU's operand side and collects its results. On a start pulse it walks element indices 0..vl-1. For each element it:
- issues synchronous register-file reads;
- presents opd1/opd2/op/vm to the combinational ALU;
- writes each result back, or packs compare results into a mask word.

It sits between the vector register file and the ALU in the execute stage.

## Interface
Parameters:
- VLMAX, 8, maximum elements per instruction (power of two, 2..32)
- IDXW, 3, index width, log2(VLMAX)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- vl  in  6  requested element count; clamped to VLMAX
- op  in  5  ALU opcode, latched at start
- masked  in  1  1 = instruction uses v0 mask; 0 = all elements active
- busy  out  1  high from the accepted start until the cycle done pulses (inclusive)
- done  out  1  one-cycle completion pulse
- rd_idx  out  IDXW  element index to the register file; read data returns next cycle
- rd_en  out  1  read strobe
- rd_opd1  in  32  vs1 element (or scalar operand), valid the cycle after rd_en
- rd_opd2  in  32  vs2 element, valid the cycle after rd_en
- rd_v0  in  1  v0 mask bit for that element, valid the cycle after rd_en
- alu_opd1, alu_opd2  out  32  ALU operands, driven from rd_opd1/rd_opd2
- alu_op  out  5  latched op
- alu_vm  out  1  element enable to the ALU: masked ? rd_v0 : 1
- alu_result  in  32  combinational ALU result
- wr_en  out  1  element write strobe
- wr_idx  out  IDXW  destination element index
- wr_data  out  32  alu_result, passed through combinationally
- mask_out  out  VLMAX  packed compare result; valid while done=1

## Operation
- States:
  - IDLE: start=1 → RUN. Latch op, masked, and eff_vl = min(vl, VLMAX). Clear mask accumulator.
  - RUN: rd_en=1, rd_idx=cnt, cnt increments each cycle. Issuing index eff_vl-1 → DRAIN.
  - DRAIN: one cycle for the last element's write/accumulate → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Zero length: start with eff_vl==0 goes IDLE → DONE with no reads, no writes, mask_out=0.
- Element stage, registered by one cycle after each read: stage_valid, stage_idx.
- In the element stage, when stage_valid:
  - Compare ops (01001..10000): no wr_en. mask_acc[stage_idx] = alu_result[0]. Masked-off elements give 0 from the ALU and record 0.
  - vmerge/vmv (10101): wr_en=1 always. The ALU selects opd1/opd2 by alu_vm.
  - Other ops: wr_en = alu_vm. Masked-off destination elements are left undisturbed, not zeroed.
- mask_out = mask_acc; it holds its value until the next accepted start.
- start outside IDLE is ignored; no queueing.
- rst in any state:
  - next cycle IDLE, cnt=0, stage_valid=0, mask_acc=0;
  - no further rd_en/wr_en;
  - an in-flight instruction is abandoned and done never pulses for it.

## Timing
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, rd_idx=0, wr_idx=0, mask_out=0, alu_op=0. alu_vm is 0 because stage_valid=0.
- Start accepted at edge T0:
  - rd_en for element i is high in cycle T0+1+i;
  - the write/accumulate for element i happens in cycle T0+2+i;
  - done is high in cycle T0+eff_vl+2.
- Throughput: one element per cycle, no bubbles.
- Total busy cycles = eff_vl+2. For eff_vl=0, busy=1 cycle (DONE only).
- Back-to-back: start in the cycle after done is accepted. A start in the same cycle as done is ignored.
- wr_idx equals the rd_idx of the previous cycle. wr_data is valid only while wr_en=1.

## Test plan
- vadd, vl=4, masked=0, vs1={1,2,3,4}, vs2={10,20,30,40} → wr_en idx0..3 with data 11,22,33,44 on consecutive cycles; done at T0+6.
- vsub, masked=1, v0=1010, vl=4 → writes only at idx1 and idx3; wr_en low at idx0 and idx2.
- vmslt, vl=8, vs1={-1,5,0,7,-8,2,2,3}, vs2={0,5,1,-7,-9,3,2,4} → zero wr_en; mask_out=8'b1010_0101 (bit i = element i) at done.
- vmerge, masked=1, v0=01, vs1={100,200}, vs2={7,9} → writes 7 (idx0), 200 (idx1).
- vl=0 → done one cycle after start, no rd_en/wr_en. vl=40 with VLMAX=8 → exactly 8 writes.
- rst asserted at T0+3 of a vl=8 run → from T0+4 busy=0, no strobes, no done. A new start afterwards runs cleanly.
